stage_ex: RTL

- Execute stage of the 5-stage RV32 turbo pipeline, between decode (upstream) and memory access (downstream).
- Computes ALU/shift results and resolves branches/jumps, then redirects fetch.
- Builds the downstream memory-control word: read/write flags and byte strobes.
- Aligns store data and holds each result until the memory-access stage accepts it.

---
 rtl/stage_ex_pkg.sv | 60 ++++++
 rtl/ex_store_align.sv | 28 ++
 rtl/stage_ex.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/stage_ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, control bits, FSM states and funct3 values.
// The memory-access stage imports the same funct3 constants.
package stage_ex_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLT    = 4'd5;
  localparam logic [3:0] OP_SLTU   = 4'd6;
  localparam logic [3:0] OP_SLL    = 4'd7;
  localparam logic [3:0] OP_SRL    = 4'd8;
  localparam logic [3:0] OP_SRA    = 4'd9;
  localparam logic [3:0] OP_PASSB  = 4'd10;
  localparam logic [3:0] OP_MUL    = 4'd11;
  localparam logic [3:0] OP_MULH   = 4'd12;
  localparam logic [3:0] OP_MULHSU = 4'd13;
  localparam logic [3:0] OP_MULHU  = 4'd14;

  // Ctl = {Branch, Jump, MemW, MemR}
  localparam int CTL_BRANCH = 3;
  localparam int CTL_JUMP   = 2;
  localparam int CTL_MEMW   = 1;
  localparam int CTL_MEMR   = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
    logic r;
    case (f3)
      F3_BEQ:  r = (a == b);
      F3_BNE:  r = (a != b);
      F3_BLT:  r = ($signed(a) < $signed(b));
      F3_BGE:  r = ($signed(a) >= $signed(b));
      F3_BLTU: r = (a < b);
      F3_BGEU: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_store_align.sv
// Store byte-strobe generation and store data replication across the 32-bit bus.
module ex_store_align
  import stage_ex_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2d,
  output logic [3:0]  strb,
  output logic [31:0] wdw
);

  always_comb begin
    strb = 4'hF;
    wdw  = rs2d;
    case (funct3)
      F3_SB: begin
        strb = 4'b0001 << addr;
        wdw  = {4{rs2d[7:0]}};
      end
      F3_SH: begin
        strb = 4'b0011 << {addr[1], 1'b0};
        wdw  = {2{rs2d[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_ex.sv
// Execute stage: ALU, branch/jump resolution, memory control word and result hold toward memory access.
// Optional macro STAGE_EX_MUL_EN adds a 32-iteration shift-add multiplier (state S_MUL).
//
// state  | meaning
// S_IDLE | empty, accepting Done_I
// S_HOLD | result valid on Done_O until Next_Ready
// S_MUL  | multiply in progress, not accepting
module stage_ex
  import stage_ex_pkg::*;
#(
  parameter int          XLEN   = 32,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_I,
  input  logic            Done_I,
  input  logic [3:0]      ALUop,
  input  logic [XLEN-1:0] OpA,
  input  logic [XLEN-1:0] OpB,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] RS2D,
  input  logic [2:0]      Funct3_I,
  input  logic [4:0]      RWA_I,
  input  logic [3:0]      Ctl,
  input  logic            Next_Ready,
  output logic            Ready_O,
  output logic [XLEN-1:0] PC_O,
  output logic            Done_O,
  output logic [5:0]      MCW,
  output logic [XLEN-1:0] WDW,
  output logic [XLEN-1:0] MAddr_O,
  output logic [4:0]      RWA_O,
  output logic [2:0]      Funct3_O,
  output logic            Br_Taken,
  output logic [XLEN-1:0] Br_Target
);

  logic [1:0]  state, state_nxt;
  logic        accept, start_mul, take;
  logic [31:0] alu_res, mem_addr, res_c, target_c, wdw_c;
  logic [3:0]  strb_c;
  logic [5:0]  mcw_c;
  logic [4:0]  rwa_c;

  assign Ready_O = (state == S_IDLE) || ((state == S_HOLD) && Next_Ready);
  assign Done_O  = (state == S_HOLD);
  assign accept  = Done_I && Ready_O;

  always_comb begin
    case (ALUop)
      OP_ADD:   alu_res = OpA + OpB;
      OP_SUB:   alu_res = OpA - OpB;
      OP_AND:   alu_res = OpA & OpB;
      OP_OR:    alu_res = OpA | OpB;
      OP_XOR:   alu_res = OpA ^ OpB;
      OP_SLT:   alu_res = {31'b0, $signed(OpA) < $signed(OpB)};
      OP_SLTU:  alu_res = {31'b0, OpA < OpB};
      OP_SLL:   alu_res = OpA << OpB[4:0];
      OP_SRL:   alu_res = OpA >> OpB[4:0];
      OP_SRA:   alu_res = $unsigned($signed(OpA) >>> OpB[4:0]);
      OP_PASSB: alu_res = OpB;
      default:  alu_res = '0;
    endcase
  end

  assign mem_addr = OpA + OpB;

  ex_store_align u_align (
    .funct3 (Funct3_I),
    .addr   (mem_addr[1:0]),
    .rs2d   (RS2D),
    .strb   (strb_c),
    .wdw    (wdw_c)
  );

  // For JAL decode passes PC in OpA, so one (OpA + Imm) & ~1 path serves both jump forms.
  assign target_c = Ctl[CTL_JUMP] ? ((OpA + Imm) & ~32'd1) : (PC_I + Imm);
  assign take     = Ctl[CTL_JUMP] || (Ctl[CTL_BRANCH] && branch_cond(Funct3_I, OpA, OpB));

  always_comb begin
    res_c = alu_res;
    mcw_c = 6'b0;
    if (Ctl[CTL_JUMP])
      res_c = PC_I + 32'd4;
    else if (Ctl[CTL_MEMW] || Ctl[CTL_MEMR])
      res_c = mem_addr;
    if (Ctl[CTL_MEMW])
      mcw_c = {2'b10, strb_c};
    else if (Ctl[CTL_MEMR])
      mcw_c = 6'b01_0000;
    rwa_c = (Ctl[CTL_BRANCH] || Ctl[CTL_MEMW]) ? 5'd0 : RWA_I;
  end

`ifdef STAGE_EX_MUL_EN
  logic [4:0]  mul_cnt;
  logic [63:0] mul_acc, mul_acc_nxt, mul_fix;
  logic [31:0] mul_a, mul_res;
  logic        mul_neg, mul_hi, a_sgn, b_sgn;
  logic [32:0] mul_sum;

  assign start_mul = is_mul_op(ALUop);
  assign a_sgn     = (ALUop != OP_MULHU) && OpA[31];
  assign b_sgn     = ((ALUop == OP_MUL) || (ALUop == OP_MULH)) && OpB[31];

  assign mul_sum     = {1'b0, mul_acc[63:32]} + (mul_acc[0] ? {1'b0, mul_a} : 33'd0);
  assign mul_acc_nxt = {mul_sum, mul_acc[31:1]};
  assign mul_fix     = mul_neg ? (64'd0 - mul_acc_nxt) : mul_acc_nxt;
  assign mul_res     = mul_hi ? mul_fix[63:32] : mul_fix[31:0];
`else
  assign start_mul = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = start_mul ? S_MUL : S_HOLD;
      S_HOLD: begin
        if (accept)          state_nxt = start_mul ? S_MUL : S_HOLD;
        else if (Next_Ready) state_nxt = S_IDLE;
      end
`ifdef STAGE_EX_MUL_EN
      S_MUL:  if (mul_cnt == 5'd31) state_nxt = S_HOLD;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      PC_O      <= RST_PC;
      MCW       <= '0;
      WDW       <= '0;
      MAddr_O   <= '0;
      RWA_O     <= '0;
      Funct3_O  <= '0;
      Br_Taken  <= 1'b0;
      Br_Target <= '0;
`ifdef STAGE_EX_MUL_EN
      mul_cnt   <= '0;
      mul_acc   <= '0;
      mul_a     <= '0;
      mul_neg   <= 1'b0;
      mul_hi    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      Br_Taken <= accept && take;
      if (accept) begin
        PC_O      <= PC_I;
        MCW       <= mcw_c;
        WDW       <= Ctl[CTL_MEMW] ? wdw_c : 32'd0;
        MAddr_O   <= res_c;
        RWA_O     <= rwa_c;
        Funct3_O  <= Funct3_I;
        Br_Target <= target_c;
      end
`ifdef STAGE_EX_MUL_EN
      if (accept && start_mul) begin
        mul_cnt <= '0;
        mul_a   <= a_sgn ? (32'd0 - OpA) : OpA;
        mul_acc <= {32'd0, b_sgn ? (32'd0 - OpB) : OpB};
        mul_neg <= a_sgn ^ b_sgn;
        mul_hi  <= (ALUop != OP_MUL);
      end else if (state == S_MUL) begin
        mul_cnt <= mul_cnt + 5'd1;
        mul_acc <= mul_acc_nxt;
        if (mul_cnt == 5'd31) MAddr_O <= mul_res;
      end
`endif
    end
  end

endmodule
